// File: rtl/store_buffer_fifo.sv
// Coalescing store buffer between MEM and the D-cache: oldest-first drain, same-cycle forwarding.
// Define STORE_BUFFER_BYTE_EN for per-entry byte masks, byte merging and partial-hit detection.
module store_buffer_fifo #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DRAIN_THRESH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [DATA_W/8-1:0]        st_be,
    output logic                       st_ready,
    output logic                       sb_stall,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       ld_partial,
    output logic                       drain_valid,
    output logic [ADDR_W-1:0]          drain_addr,
    output logic [DATA_W-1:0]          drain_data,
    output logic [DATA_W/8-1:0]        drain_be,
    input  logic                       drain_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              drain_valid_q, drain_valid_d;
    logic              flush_pending_q, flush_pending_d;

    logic              st_match, ld_match, alloc, coalesce, drain_hs;
    logic [PTR_W-1:0]  st_idx, ld_idx, ld_scan;
    logic [BE_W-1:0]   st_be_eff;

`ifdef STORE_BUFFER_BYTE_EN
    logic [BE_W-1:0]   be_q [DEPTH];
    logic [BE_W-1:0]   be_d [DEPTH];
    assign st_be_eff = st_be;
    assign drain_be  = be_q[head_q];
`else
    logic              unused_st_be;
    assign unused_st_be = ^st_be;
    assign st_be_eff    = '1;
    assign drain_be     = '1;
`endif

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign drain_valid = drain_valid_q;
    assign drain_addr  = addr_q[head_q];
    assign drain_data  = data_q[head_q];

    // The head entry being presented to the cache is frozen and cannot absorb new stores.
    always_comb begin
        st_match = 1'b0;
        st_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == st_addr &&
                !(PTR_W'(i) == head_q && drain_valid_q)) begin
                st_match = 1'b1;
                st_idx   = PTR_W'(i);
            end
        end
    end

    // Scan oldest to youngest so the youngest match overrides.
    always_comb begin
        ld_match = 1'b0;
        ld_idx   = '0;
        ld_scan  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ld_scan = head_q + PTR_W'(k);
            if (valid_q[ld_scan] && addr_q[ld_scan] == ld_addr) begin
                ld_match = 1'b1;
                ld_idx   = ld_scan;
            end
        end
    end

    assign ld_data = data_q[ld_idx];
`ifdef STORE_BUFFER_BYTE_EN
    assign ld_hit     = ld_valid && ld_match && (&be_q[ld_idx]);
    assign ld_partial = ld_valid && ld_match && !(&be_q[ld_idx]);
`else
    assign ld_hit     = ld_valid && ld_match;
    assign ld_partial = 1'b0;
`endif

    assign st_ready = !full || st_match;
    assign sb_stall = st_valid && !st_ready;
    assign coalesce = st_valid && st_match;
    assign alloc    = st_valid && !st_match && !full;
    assign drain_hs = drain_valid_q && drain_ready;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef STORE_BUFFER_BYTE_EN
        be_d    = be_q;
`endif
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain_hs) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (coalesce) begin
            for (int b = 0; b < BE_W; b++) begin
                if (st_be_eff[b]) data_d[st_idx][8*b +: 8] = st_data[8*b +: 8];
            end
`ifdef STORE_BUFFER_BYTE_EN
            be_d[st_idx] = be_q[st_idx] | st_be;
`endif
        end else if (alloc) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = st_addr;
            data_d[tail_q]  = st_data;
`ifdef STORE_BUFFER_BYTE_EN
            be_d[tail_q]    = st_be;
`endif
            tail_d          = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(alloc) - CNT_W'(drain_hs);

        if (drain_hs) begin
            drain_valid_d = 1'b0;
        end else if (drain_valid_q) begin
            drain_valid_d = 1'b1;
        end else begin
            drain_valid_d = !empty && (count_q >= CNT_W'(DRAIN_THRESH) || flush_pending_q);
        end
        flush_pending_d = (flush_pending_q || (flush && !empty)) && (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            drain_valid_q   <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            valid_q         <= valid_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            drain_valid_q   <= drain_valid_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Payload storage carries no reset; valid bits qualify it.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
`ifdef STORE_BUFFER_BYTE_EN
        be_q   <= be_d;
`endif
    end

endmodule

// File: tb/tb_store_buffer_fifo.sv
// Directed bench for store_buffer_fifo (DEPTH=4, DRAIN_THRESH=4); byte-mask checks when
// STORE_BUFFER_BYTE_EN is defined.
module tb_store_buffer_fifo;
    logic        clk = 1'b0;
    logic        rst, st_valid, st_ready, sb_stall, ld_valid, ld_hit, ld_partial;
    logic        drain_valid, drain_ready, flush, empty, full;
    logic [31:0] st_addr, st_data, ld_addr, ld_data, drain_addr, drain_data;
    logic [3:0]  st_be, drain_be;
    logic [2:0]  count;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    store_buffer_fifo dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .st_ready(st_ready), .sb_stall(sb_stall),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .ld_partial(ld_partial),
        .drain_valid(drain_valid), .drain_addr(drain_addr), .drain_data(drain_data),
        .drain_be(drain_be), .drain_ready(drain_ready),
        .flush(flush), .count(count), .empty(empty), .full(full)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [31:0] a, input logic hit,
                              input logic [31:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        #1;
        check_eq({tag, "_hit"}, ld_hit, hit);
        if (hit) check_eq({tag, "_data"}, ld_data, d);
        ld_valid = 1'b0;
    endtask

    // Accepts the next presented head and checks it; a missing handshake counts as a failure.
    task automatic expect_drain(input string tag, input logic [31:0] a, input logic [31:0] d);
        bit seen = 1'b0;
        drain_ready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (drain_valid) begin
                check_eq({tag, "_addr"}, drain_addr, a);
                check_eq({tag, "_data"}, drain_data, d);
                seen = 1'b1;
            end
            tick();
        end
        drain_ready = 1'b0;
        if (!seen) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '1;
        ld_valid = 1'b0; ld_addr = '0; drain_ready = 1'b0; flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_dvalid", drain_valid, 0);
        check_eq("rst_st_ready", st_ready, 1);
        check_eq("rst_stall", sb_stall, 0);
        load_check("rst_ld", 32'h10, 1'b0, 32'h0);
        check_eq("rst_partial", ld_partial, 0);

        // Fill to threshold, then hold the head un-acknowledged.
        store(32'h10, 32'hA0, 4'hF);
        store(32'h14, 32'hA1, 4'hF);
        store(32'h18, 32'hA2, 4'hF);
        store(32'h1C, 32'hA3, 4'hF);
        check_eq("fill_full", full, 1);
        check_eq("fill_count", count, 4);
        tick();
        check_eq("fill_dvalid", drain_valid, 1);
        check_eq("fill_daddr", drain_addr, 32'h10);
        check_eq("fill_ddata", drain_data, 32'hA0);
        check_eq("fill_dbe", drain_be, 4'hF);

        st_valid = 1'b1; st_addr = 32'h40; st_data = 32'hEE;
        #1;
        check_eq("full_st_ready", st_ready, 0);
        check_eq("full_stall", sb_stall, 1);
        tick();
        st_valid = 1'b0;
        check_eq("full_refused_count", count, 4);
        check_eq("hold1_addr", drain_addr, 32'h10);

        st_valid = 1'b1; st_addr = 32'h18; st_data = 32'hB2;
        #1;
        check_eq("coal_full_ready", st_ready, 1);
        check_eq("coal_full_stall", sb_stall, 0);
        tick();
        st_valid = 1'b0;
        check_eq("coal_full_count", count, 4);
        check_eq("hold2_dvalid", drain_valid, 1);
        load_check("fwd_18", 32'h18, 1'b1, 32'hB2);
        load_check("fwd_head", 32'h10, 1'b1, 32'hA0);
        tick();
        check_eq("hold3_dvalid", drain_valid, 1);
        check_eq("hold3_addr", drain_addr, 32'h10);
        check_eq("hold3_data", drain_data, 32'hA0);

        drain_ready = 1'b1;
        tick();
        drain_ready = 1'b0;
        check_eq("hs_count", count, 3);
        check_eq("hs_dvalid_drop", drain_valid, 0);
        check_eq("hs_next_head", drain_addr, 32'h14);
        tick();
        check_eq("below_thresh_idle", drain_valid, 0);

        // Flush drains everything left, oldest first.
        pulse_flush();
        expect_drain("fl0", 32'h14, 32'hA1);
        expect_drain("fl1", 32'h18, 32'hB2);
        expect_drain("fl2", 32'h1C, 32'hA3);
        check_eq("fl_empty", empty, 1);
        check_eq("fl_pending", dut.flush_pending_q, 0);

        pulse_flush();
        check_eq("fl_empty_noop", dut.flush_pending_q, 0);
        tick();
        check_eq("fl_empty_dvalid", drain_valid, 0);

        store(32'h20, 32'h11, 4'hF);
        store(32'h20, 32'h22, 4'hF);
        check_eq("coal_count", count, 1);
        load_check("coal_ld", 32'h20, 1'b1, 32'h22);
        load_check("coal_miss", 32'h24, 1'b0, 32'h0);
        ld_addr = 32'h20;
        #1;
        check_eq("ld_invalid", ld_hit, 0);

        // Store to the head while it is being presented must allocate a fresh entry.
        pulse_flush();
        tick();
        check_eq("hid_dvalid", drain_valid, 1);
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'h55;
        #1;
        check_eq("hid_st_ready", st_ready, 1);
        tick();
        st_valid = 1'b0;
        check_eq("hid_count", count, 2);
        check_eq("hid_head_stable", drain_data, 32'h22);
        load_check("hid_young", 32'h20, 1'b1, 32'h55);
        expect_drain("hid_old", 32'h20, 32'h22);
        expect_drain("hid_new", 32'h20, 32'h55);
        check_eq("hid_empty", empty, 1);

        // Allocate and drain on the same edge.
        store(32'h70, 32'h1, 4'hF);
        pulse_flush();
        tick();
        check_eq("sim_dvalid", drain_valid, 1);
        drain_ready = 1'b1;
        st_valid = 1'b1; st_addr = 32'h74; st_data = 32'h2;
        tick();
        st_valid = 1'b0; drain_ready = 1'b0;
        check_eq("sim_count", count, 1);
        expect_drain("sim_next", 32'h74, 32'h2);

        // Reset while a head is presented but never accepted.
        store(32'h80, 32'h1, 4'hF);
        store(32'h84, 32'h2, 4'hF);
        store(32'h88, 32'h3, 4'hF);
        store(32'h8C, 32'h4, 4'hF);
        tick();
        check_eq("rd_dvalid", drain_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rd_dvalid_drop", drain_valid, 0);
        check_eq("rd_count", count, 0);
        load_check("rd_ld", 32'h80, 1'b0, 32'h0);

`ifdef STORE_BUFFER_BYTE_EN
        store(32'h30, 32'h0000BEEF, 4'b0011);
        ld_valid = 1'b1; ld_addr = 32'h30;
        #1;
        check_eq("be_partial", ld_partial, 1);
        check_eq("be_partial_hit", ld_hit, 0);
        ld_valid = 1'b0;
        store(32'h30, 32'hDEAD0000, 4'b1100);
        load_check("be_merged", 32'h30, 1'b1, 32'hDEADBEEF);
        check_eq("be_count", count, 1);
        check_eq("be_drain_be", drain_be, 4'hF);
`else
        store(32'h30, 32'h0000BEEF, 4'b0011);
        ld_valid = 1'b1; ld_addr = 32'h30;
        #1;
        check_eq("nobe_partial", ld_partial, 0);
        check_eq("nobe_hit", ld_hit, 1);
        ld_valid = 1'b0;
        check_eq("nobe_drain_be", drain_be, 4'hF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/store_buffer_fifo.md
Name: store_buffer_fifo

Overview:
- Parametrised successor to the 4-entry store buffer between the MEM stage and the D-cache.
- Holds retired stores in a FIFO ordered oldest-first and coalesces repeat stores to the same word.
- Forwards buffered data to loads in the same cycle.
- Drains the oldest entry to the cache over a valid/ready handshake, triggered by an occupancy threshold or an explicit flush.

Parameters:
- DATA_W, 32, data word width in bits (multiple of 8).
- ADDR_W, 32, word-address width; compare is exact on all bits.
- DEPTH, 4, number of entries (power of two, >= 2).
- DRAIN_THRESH, 4, occupancy at or above which draining starts (1..DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- st_valid  in  1  store request.
- st_addr  in  ADDR_W  store address.
- st_data  in  DATA_W  store data.
- st_be  in  DATA_W/8  store byte enables (used only with the optional feature).
- st_ready  out  1  store accepted this cycle when st_valid & st_ready.
- sb_stall  out  1  st_valid & !st_ready, drives the pipeline stall.
- ld_valid  in  1  load lookup.
- ld_addr  in  ADDR_W  load address.
- ld_hit  out  1  forwarding hit.
- ld_data  out  DATA_W  forwarded data, valid when ld_hit.
- ld_partial  out  1  match exists but does not cover the load (optional feature only).
- drain_valid  out  1  head entry presented to the cache.
- drain_addr  out  ADDR_W  head address.
- drain_data  out  DATA_W  head data.
- drain_be  out  DATA_W/8  head byte mask.
- drain_ready  in  1  cache accepts the head.
- flush  in  1  one-cycle pulse: drain until empty.
- count  out  $clog2(DEPTH+1)  occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset:
  - All valid bits cleared; head=tail=0; count=0.
  - drain_valid=0, flush_pending=0, st_ready=1, ld_hit=0, ld_partial=0, sb_stall=0.
  - Data and address storage is not reset.
- Storage: circular array with head (oldest) and tail (next free) pointers. Pointers wrap modulo DEPTH.
- Store match: st_addr equals a valid entry's address. The match is coalescible unless that entry is the head while drain_valid=1.
- Coalesce:
  - Overwrites the data in place (byte-merged under the feature).
  - count unchanged.
  - Accepted even when full.
- Allocate (no coalescible match): writes at tail, tail+1, count+1. Requires !full.
- st_ready = !full | coalescible match. Combinational.
- Store-to-load forwarding:
  - Combinational, same cycle.
  - Compares against registered state only; a store accepted in the same cycle is not visible.
  - If several entries match, which can only happen via the head-in-drain case, the youngest wins.
  - ld_hit=0 when ld_valid=0.
- Drain trigger:
  - drain_valid rises on the cycle after !empty & (count>=DRAIN_THRESH | flush_pending).
  - Once raised, drain_valid stays high and drain_addr, drain_data and drain_be stay stable until drain_ready is seen.
- Drain handshake (drain_valid & drain_ready):
  - Head entry invalidated, head+1, count-1.
  - drain_valid drops for one cycle, then is re-evaluated.
- Simultaneous allocate and drain: count unchanged. Allocate while full is still refused in that cycle, because st_ready does not look ahead.
- Flush:
  - A pulse sets flush_pending.
  - flush_pending clears the cycle count reaches 0.
  - A flush while already empty has no effect.
  - Stores continue to be accepted during a flush; they extend the flush.
- rst asserted mid-drain: everything clears next edge and drain_valid drops, even if drain_ready was never seen (the cache side must tolerate this).
- full, empty and count are registered-state derived, with no combinational path from st_valid.

Optional Feature:
- Macro: STORE_BUFFER_BYTE_EN.
- Defined:
  - Each entry holds a DATA_W/8 byte mask.
  - Allocation stores st_be.
  - Coalescing ORs the masks and replaces only enabled bytes.
  - A load hits only if the matching entry's mask is all ones. Otherwise ld_hit=0 and ld_partial=1, and the core must stall until drained.
  - drain_be = head mask.
- Undefined:
  - st_be ignored; masks are all ones.
  - ld_partial tied to 0; drain_be all ones.

Test Plan:
- Fill and drain (DEPTH=4, THRESH=4): reset, then stores to 0x10, 0x14, 0x18, 0x1C with data 0xA0..0xA3 → full=1 after the 4th; drain_valid next cycle with addr 0x10/data 0xA0. Hold drain_ready low 3 cycles → outputs stable. Then drain_ready=1 → count=3, next head 0x14.
- Coalesce: store 0x20/0x11, then 0x20/0x22 → count=1. Load 0x20 → ld_hit=1, ld_data=0x22. Load 0x24 → ld_hit=0.
- Full stall: with 4 entries, store to new 0x40 → st_ready=0, sb_stall=1. Same cycle, store to existing non-head 0x18 → accepted, count stays 4.
- Flush: 2 entries then a flush pulse → both drain in order with drain_ready=1; empty=1 and flush_pending=0 after the second handshake.
- Head-in-drain conflict: head 0x10 presented with drain_ready=0, store 0x10/0x55 → new entry allocated. Load 0x10 returns 0x55. Drain delivers the old data first.
- Byte (STORE_BUFFER_BYTE_EN): store 0x30 be=0011 data 0x0000BEEF → load 0x30 gives ld_partial=1, ld_hit=0. Then store be=1100 data 0xDEAD0000 → ld_hit=1, ld_data=0xDEADBEEF, count=1.
